// File: rtl/arrow_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : arrow_pulse_gen
// Description : Dance-step prompt generator. Emits one arrow pulse per beat
//               on one of four lanes (lane picked by a 16-bit Galois LFSR)
//               for a requested number of steps, then pulses done.
//               Optional macro ARROW_CHORD_EN: when lfsr[2] is set on an
//               emit, the opposite lane ((lane+2) mod 4) is lit as well.
// Revision    : 1.0 - initial release
// ============================================================================
module arrow_pulse_gen #(
    parameter int unsigned BEAT_DIV  = 25000000,
    parameter int unsigned STEPS_W   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [STEPS_W-1:0] num_steps,
    input  logic               pause,
    output logic [3:0]         arrow_pulse,
    output logic [3:0]         arrow_level,
    output logic [STEPS_W-1:0] step_count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned c_TIMER_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(BEAT_DIV - 1);
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]           r_state,  w_state;
    logic [15:0]          r_lfsr,   w_lfsr;
    logic [c_TIMER_W-1:0] r_timer,  w_timer;
    logic [STEPS_W-1:0]   r_steps,  w_steps;
    logic [STEPS_W-1:0]   r_target, w_target;
    logic [3:0]           r_pulse,  w_pulse;
    logic [3:0]           r_level,  w_level;
    logic                 r_busy,   w_busy;
    logic                 r_done,   w_done;

    logic [15:0] w_lfsr_step;
    logic [3:0]  w_lane_mask;
    logic [3:0]  w_chord_mask;
    logic        w_chord;
    logic [3:0]  w_emit_mask;

    // Galois right-shift step; the lane for an emit comes from the current value.
    assign w_lfsr_step  = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    assign w_lane_mask  = 4'b0001 << r_lfsr[1:0];
    assign w_chord_mask = 4'b0001 << (r_lfsr[1:0] + 2'd2);

`ifdef ARROW_CHORD_EN
    assign w_chord = r_lfsr[2];
`else
    assign w_chord = 1'b0;
`endif

    assign w_emit_mask = w_lane_mask | (w_chord ? w_chord_mask : 4'b0000);

    // Next-state and next-output decode; everything holds unless a branch says otherwise.
    always_comb begin
        w_state  = r_state;
        w_lfsr   = r_lfsr;
        w_timer  = r_timer;
        w_steps  = r_steps;
        w_target = r_target;
        w_pulse  = 4'b0000;
        w_level  = r_level;
        w_busy   = 1'b0;
        w_done   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_steps = '0;
                    w_level = 4'b0000;
                    if (num_steps != '0) begin
                        w_state  = c_ST_RUN;
                        w_target = num_steps;
                        w_timer  = '0;
                        w_busy   = 1'b1;
                    end else begin
                        w_state = c_ST_DONE;
                        w_done  = 1'b1;
                    end
                end
            end

            c_ST_RUN: begin
                w_busy = 1'b1;
                if (r_steps == r_target) begin
                    // Final emit happened last cycle: wrap up regardless of pause.
                    w_state = c_ST_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_level = 4'b0000;
                end else if (!pause) begin
                    if (r_timer == c_TIMER_LAST) begin
                        w_timer = '0;
                        w_pulse = w_emit_mask;
                        w_level = w_emit_mask;
                        w_steps = r_steps + STEPS_W'(1);
                        w_lfsr  = w_lfsr_step;
                    end else begin
                        w_timer = r_timer + c_TIMER_W'(1);
                    end
                end
            end

            c_ST_DONE: begin
                w_state = c_ST_IDLE;
            end

            default: begin
                w_state = c_ST_IDLE;
                w_level = 4'b0000;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state  <= c_ST_IDLE;
            r_lfsr   <= LFSR_SEED;
            r_timer  <= '0;
            r_steps  <= '0;
            r_target <= '0;
            r_pulse  <= 4'b0000;
            r_level  <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_lfsr   <= w_lfsr;
            r_timer  <= w_timer;
            r_steps  <= w_steps;
            r_target <= w_target;
            r_pulse  <= w_pulse;
            r_level  <= w_level;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign arrow_pulse = r_pulse;
    assign arrow_level = r_level;
    assign step_count  = r_steps;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire
